// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DSIZE-bit entries and emits PACK of them as
// one wide word on a valid/ready stream.
// Optional feature macro: RD_PACK_FLUSH_EN adds a flush input that emits a partial word.
module fifo_rd_packer #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned PACK  = 4,
   localparam int unsigned CW   = $clog2(PACK + 1)
) (
`ifdef RD_PACK_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic [DSIZE-1:0]      rd_data,
   input  logic                  rd_empty,
   output logic                  rd_en,
   output logic [DSIZE*PACK-1:0] out_data,
   output logic [CW-1:0]         out_count,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned OW = DSIZE * PACK;
   // The last lane is never stored: it goes straight from rd_data into the output word.
   localparam int unsigned AW = DSIZE * (PACK - 1);
   localparam logic [CW-1:0] LastLane = CW'(PACK - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [OW-1:0] odata_q, odata_d;
   logic [CW-1:0] ocount_q, ocount_d;
   logic          ovalid_q, ovalid_d;
   logic          last_lane, xfer, stall, pop;
`ifdef RD_PACK_FLUSH_EN
   logic          pend_q, pend_d;
`endif

   // Pop control: only the completing pop waits for the output slot.
   always_comb begin
      last_lane = (cnt_q == LastLane);
      xfer      = ovalid_q & out_ready;
      stall     = last_lane & ovalid_q & ~out_ready;
      pop       = rd_rst_n & ~rd_empty & ~stall;
`ifdef RD_PACK_FLUSH_EN
      pop       = pop & ~pend_q;
`endif
   end

   assign rd_en     = pop;
   assign out_data  = odata_q;
   assign out_count = ocount_q;
   assign out_valid = ovalid_q;

   // Next-state: lane fill, word completion, output handshake and optional flush.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      odata_d  = odata_q;
      ocount_d = ocount_q;
      ovalid_d = ovalid_q;
`ifdef RD_PACK_FLUSH_EN
      pend_d   = pend_q;
`endif
      if (xfer) begin
         ovalid_d = 1'b0;
      end
      if (pop) begin
         if (last_lane) begin
            // A transfer on this same edge frees the slot, so there is no bubble.
            odata_d  = {rd_data, acc_q};
            ocount_d = CW'(PACK);
            ovalid_d = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
         end else begin
            acc_d[int'(cnt_q) * DSIZE +: DSIZE] = rd_data;
            cnt_d = cnt_q + CW'(1);
         end
      end
`ifdef RD_PACK_FLUSH_EN
      if (flush && (cnt_q != '0)) begin
         pend_d = 1'b1;
      end
      if (pend_q && (!ovalid_q || xfer)) begin
         pend_d = 1'b0;
         if (cnt_q != '0) begin
            // Unfilled lanes are already zero because the accumulator clears per word.
            odata_d  = OW'(acc_q);
            ocount_d = cnt_q;
            ovalid_d = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
         end
      end
`endif
   end

   // State registers; reset discards any partial word.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         odata_q  <= '0;
         ocount_q <= '0;
         ovalid_q <= 1'b0;
`ifdef RD_PACK_FLUSH_EN
         pend_q   <= 1'b0;
`endif
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         odata_q  <= odata_d;
         ocount_q <= ocount_d;
         ovalid_q <= ovalid_d;
`ifdef RD_PACK_FLUSH_EN
         pend_q   <= pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer (DSIZE=8, PACK=4) with a behavioural FIFO and a word scoreboard.
module tb_fifo_rd_packer;

   logic        rd_clk = 1'b0;
   logic        rd_rst_n = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_empty;
   logic        rd_en;
   logic [31:0] out_data;
   logic [2:0]  out_count;
   logic        out_valid;
   logic        out_ready = 1'b1;
`ifdef RD_PACK_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   // FIFO model: head is combinational, pointer advances on rd_en at the clock edge.
   logic [7:0] fifo_mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign rd_data  = fifo_mem[rd_ptr % 256];
   assign rd_empty = (rd_ptr == wr_ptr);

   typedef struct {
      logic [31:0] data;
      logic [2:0]  count;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] pb = '0;
   int          pn = 0;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
`ifdef RD_PACK_FLUSH_EN
      .flush     (flush),
`endif
      .rd_clk    (rd_clk),
      .rd_rst_n  (rd_rst_n),
      .rd_data   (rd_data),
      .rd_empty  (rd_empty),
      .rd_en     (rd_en),
      .out_data  (out_data),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always @(posedge rd_clk) begin
      if (rd_en) rd_ptr <= rd_ptr + 1;
   end

   // Scoreboard: each transfer must match the oldest expected word.
   always @(negedge rd_clk) begin
      if (rd_rst_n && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got word %h count %0d, required no word", out_data, out_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_data !== e.data || out_count !== e.count) begin
               bad++;
               $display("FAIL sb_word: got %h/%0d, required %h/%0d",
                        out_data, out_count, e.data, e.count);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic push_byte(input logic [7:0] b);
      fifo_mem[wr_ptr % 256] = b;
      wr_ptr++;
      pb[pn*8 +: 8] = b;
      pn++;
      if (pn == 4) begin
         exp_q.push_back('{data: pb, count: 3'd4});
         pb = '0;
         pn = 0;
      end
   endtask

   task automatic at_drive();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge rd_clk);
         if (rd_ptr == wr_ptr && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      foreach (fifo_mem[i]) fifo_mem[i] = 8'h00;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      repeat (3) @(negedge rd_clk);
      total++;
      if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0) begin
         bad++;
         $display("FAIL reset: got en=%b v=%b d=%h c=%0d, required all zero",
                  rd_en, out_valid, out_data, out_count);
      end
   endtask

   task automatic test_single_word();
      at_drive();
      rd_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge rd_clk);
         total++;
         if (rd_en !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop%0d: got en=%b v=%b, required en=1 v=0", i, rd_en, out_valid);
         end
      end
      @(negedge rd_clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_count !== 3'd4) begin
         bad++;
         $display("FAIL single_word: got v=%b d=%h c=%0d, required v=1 d=44332211 c=4",
                  out_valid, out_data, out_count);
      end
      @(negedge rd_clk);
      total++;
      if (out_valid !== 1'b0 || rd_en !== 1'b0) begin
         bad++;
         $display("FAIL single_pulse: got v=%b en=%b, required v=0 en=0", out_valid, rd_en);
      end
   endtask

   task automatic test_backpressure();
      at_drive();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'((i << 4) | i));
      repeat (10) @(negedge rd_clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h44332211 || rd_en !== 1'b0 ||
          rd_ptr != wr_ptr - 1) begin
         bad++;
         $display("FAIL bp_hold: got v=%b d=%h en=%b left=%0d, required v=1 d=44332211 en=0 left=1",
                  out_valid, out_data, rd_en, wr_ptr - rd_ptr);
      end
      at_drive();
      out_ready = 1'b1;
      @(negedge rd_clk);
      total++;
      if (rd_en !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: got en=%b, required en=1", rd_en);
      end
      @(negedge rd_clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h88776655) begin
         bad++;
         $display("FAIL bp_nobubble: got v=%b d=%h, required v=1 d=88776655", out_valid, out_data);
      end
   endtask

   task automatic test_stream();
      bit ok;
      at_drive();
      for (int i = 0; i < 32; i++) push_byte(8'($urandom_range(0, 255)));
      for (int k = 0; k < 32; k++) begin
         @(negedge rd_clk);
         total++;
         if (rd_en !== 1'b1 || out_valid !== ((k % 4 == 0) && (k > 0))) begin
            bad++;
            $display("FAIL stream_cyc%0d: got en=%b v=%b, required en=1 v=%0d",
                     k, rd_en, out_valid, (k % 4 == 0) && (k > 0));
         end
      end
      wait_idle(20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL stream_drain: got %0d words pending, required 0", exp_q.size());
      end
      // Random backpressure over a longer stream.
      at_drive();
      for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 255)));
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         at_drive();
         if (rd_ptr == wr_ptr && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL random_drain: got %0d words %0d bytes pending, required 0/0",
                  exp_q.size(), wr_ptr - rd_ptr);
      end
   endtask

`ifdef RD_PACK_FLUSH_EN
   task automatic test_flush();
      bit ok;
      at_drive();
      push_byte(8'hAA); push_byte(8'hBB);
      repeat (3) @(negedge rd_clk);
      at_drive();
      flush = 1'b1;
      exp_q.push_back('{data: pb, count: 3'(pn)});
      pb = '0;
      pn = 0;
      at_drive();
      flush = 1'b0;
      push_byte(8'hCC);
      @(negedge rd_clk);
      total++;
      if (rd_en !== 1'b0) begin
         bad++;
         $display("FAIL flush_pend: got en=%b, required en=0", rd_en);
      end
      @(negedge rd_clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_count !== 3'd2) begin
         bad++;
         $display("FAIL flush_word: got v=%b d=%h c=%0d, required v=1 d=0000BBAA c=2",
                  out_valid, out_data, out_count);
      end
      push_byte(8'hDD); push_byte(8'hEE); push_byte(8'hFF);
      wait_idle(20, ok);
      at_drive();
      flush = 1'b1;
      at_drive();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge rd_clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty%0d: got v=%b, required v=0", i, out_valid);
         end
      end
   endtask
`endif

   task automatic test_reset_midword();
      bit ok;
      bit seen;
      at_drive();
      push_byte(8'h9A); push_byte(8'h9B); push_byte(8'h9C);
      repeat (5) @(negedge rd_clk);
      at_drive();
      rd_rst_n = 1'b0;
      pb = '0;
      pn = 0;
      #1;
      total++;
      if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0) begin
         bad++;
         $display("FAIL midreset: got en=%b v=%b d=%h c=%0d, required all zero",
                  rd_en, out_valid, out_data, out_count);
      end
      at_drive();
      rd_rst_n = 1'b1;
      push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge rd_clk);
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            total++;
            if (out_data !== 32'h04030201) begin
               bad++;
               $display("FAIL midreset_word: got %h, required 04030201", out_data);
            end
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL midreset_timeout: got no out_valid, required a word");
      end
      wait_idle(20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL final_drain: got %0d words pending, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_stream();
`ifdef RD_PACK_FLUSH_EN
      test_flush();
`endif
      test_reset_midword();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
